// File: rtl/afifo_pkg.sv
// Shared pointer helpers for the async FIFO write and read control blocks.
// Pointers travel in a wide container so one function pair serves any pointer width.
package afifo_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down; bits at or above width are forced to zero.
    function automatic ptr_max_t gray2bin(input ptr_max_t gray, input int unsigned width);
        ptr_max_t bin;
        logic     acc;
        bin = '0;
        acc = 1'b0;
        for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
            if (i < int'(width)) begin
                acc = acc ^ gray[i];
            end
            bin[i] = acc;
        end
        return bin;
    endfunction

endpackage

// File: rtl/afifo_sync2.sv
// Two-flop synchronizer for bringing a Gray pointer into the local clock domain.
// Shared by the write-side and read-side FIFO control.
module afifo_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-domain control of the async FIFO: pointers, full/almost-full/level,
// sticky overflow and the memory write port.
module afifo_wr_ctrl
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    input  logic                  wovf_clr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  wovf
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    localparam ptr_t AFULL_LVL = ptr_t'(AFULL_THRESH);

    ptr_t wbin;
    ptr_t wbin_next;
    ptr_t wgray_next;
    ptr_t rq2;
    ptr_t rbin_sync;
    ptr_t full_gray;
    ptr_t level_next;

    afifo_sync2 #(
        .WIDTH (PTR_W)
    ) u_rptr_sync (
        .clk (wclk),
        .rst (wrst),
        .d   (rptr_gray),
        .q   (rq2)
    );

    assign mem_wen   = winc & ~wfull;
    assign mem_waddr = wbin[ADDR_WIDTH-1:0];
    assign mem_wdata = wdata;

    assign wbin_next  = wbin + ptr_t'(mem_wen);
    assign wgray_next = ptr_t'(bin2gray(ptr_max_t'(wbin_next)));
    assign rbin_sync  = ptr_t'(gray2bin(ptr_max_t'(rq2), PTR_W));

    // Full when the write pointer has lapped the read pointer by exactly one depth.
    assign full_gray  = {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]};
    assign level_next = wbin_next - rbin_sync;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin         <= '0;
            wptr_gray    <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbin_next;
            wptr_gray    <= wgray_next;
            wfull        <= (wgray_next == full_gray);
            walmost_full <= (level_next >= AFULL_LVL);
            wlevel       <= level_next;
            // A dropped write outranks a simultaneous clear.
            if (winc && wfull) begin
                wovf <= 1'b1;
            end else if (wovf_clr) begin
                wovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Bench for afifo_wr_ctrl at depth 16: directed steps, a cycle model of the
// write-side status and a data scoreboard checked through a read model.
module tb_afifo_wr_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TH = 12;

    logic          wclk      = 1'b0;
    logic          wrst      = 1'b1;
    logic          winc      = 1'b0;
    logic [DW-1:0] wdata     = '0;
    logic [AW:0]   rptr_gray = '0;
    logic          wovf_clr  = 1'b0;
    logic [AW:0]   wptr_gray;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          wfull;
    logic          walmost_full;
    logic [AW:0]   wlevel;
    logic          wovf;

    always #5 wclk = ~wclk;

    afifo_wr_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .AFULL_THRESH (TH)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .winc         (winc),
        .wdata        (wdata),
        .rptr_gray    (rptr_gray),
        .wovf_clr     (wovf_clr),
        .wptr_gray    (wptr_gray),
        .mem_wen      (mem_wen),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    // Dual-port memory stand-in driven by the DUT write port.
    logic [DW-1:0] tbmem [16];
    always @(posedge wclk) begin
        if (mem_wen) tbmem[mem_waddr] <= mem_wdata;
    end

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] sb [$];

    logic [AW:0] e_wbin  = '0;
    logic [AW:0] e_q1    = '0;
    logic [AW:0] e_q2    = '0;
    logic        e_full  = 1'b0;
    logic        e_af    = 1'b0;
    logic        e_ovf   = 1'b0;
    logic [AW:0] e_level = '0;
    logic [AW:0] prev_gray = '0;
    logic [AW:0] r_bin   = '0;
    int          n_acc   = 0;

    function automatic logic [AW:0] b2g(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] g2b(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        e_wbin = '0; e_q1 = '0; e_q2 = '0; e_full = 1'b0; e_af = 1'b0;
        e_ovf = 1'b0; e_level = '0; prev_gray = '0; r_bin = '0;
        sb.delete();
    endtask

    // One wclk cycle: check the write port, advance the model, check registered status.
    task automatic step();
        logic        wen;
        logic [AW:0] wn;
        logic [AW:0] lvl;
        #1;
        wen = winc & ~e_full;
        chk("mem_wen", {31'd0, mem_wen}, {31'd0, wen});
        chk("mem_waddr", {28'd0, mem_waddr}, {28'd0, e_wbin[AW-1:0]});
        chk("mem_wdata", mem_wdata, wdata);
        if (wen) begin
            sb.push_back(wdata);
            n_acc++;
        end
        @(posedge wclk);
        wn  = e_wbin + {{AW{1'b0}}, wen};
        lvl = wn - g2b(e_q2);
        if (winc && e_full) e_ovf = 1'b1;
        else if (wovf_clr) e_ovf = 1'b0;
        e_full  = (b2g(wn) == {~e_q2[AW:AW-1], e_q2[AW-2:0]});
        e_af    = (int'(lvl) >= TH);
        e_level = lvl;
        e_q2    = e_q1;
        e_q1    = rptr_gray;
        e_wbin  = wn;
        #1;
        chk("wptr_gray", {27'd0, wptr_gray}, {27'd0, b2g(e_wbin)});
        chk("wfull", {31'd0, wfull}, {31'd0, e_full});
        chk("wlevel", {27'd0, wlevel}, {27'd0, e_level});
        chk("walmost_full", {31'd0, walmost_full}, {31'd0, e_af});
        chk("wovf", {31'd0, wovf}, {31'd0, e_ovf});
        chk("gray_one_bit", {31'd0, ($countones(wptr_gray ^ prev_gray) <= 1)}, 32'd1);
        chk("full_at_16", {31'd0, (!wfull || wlevel == 5'd16)}, 32'd1);
        prev_gray = wptr_gray;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        #2;
        wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; rptr_gray = '0;
        #1;
        chk("rst_wptr_gray", {27'd0, wptr_gray}, 32'd0);
        chk("rst_wfull", {31'd0, wfull}, 32'd0);
        chk("rst_walmost_full", {31'd0, walmost_full}, 32'd0);
        chk("rst_wlevel", {27'd0, wlevel}, 32'd0);
        chk("rst_wovf", {31'd0, wovf}, 32'd0);
        chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_mem_waddr", {28'd0, mem_waddr}, 32'd0);
        model_clear();
        @(posedge wclk);
        #1;
        wrst = 1'b0;
    endtask

    task automatic read_one();
        logic [DW-1:0] exp_d;
        exp_d = sb.pop_front();
        chk("read_data", tbmem[r_bin[AW-1:0]], exp_d);
        r_bin     = r_bin + 1'b1;
        rptr_gray = b2g(r_bin);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge wclk);
        #1;
        chk("init_wptr_gray", {27'd0, wptr_gray}, 32'd0);
        chk("init_wfull", {31'd0, wfull}, 32'd0);
        chk("init_wlevel", {27'd0, wlevel}, 32'd0);
        chk("init_wovf", {31'd0, wovf}, 32'd0);
        wrst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            winc  = 1'b1;
            wdata = $urandom;
            #1;
            chk("fill_waddr", {28'd0, mem_waddr}, i);
            step();
            chk("fill_afull", {31'd0, walmost_full}, (i + 1 >= TH) ? 32'd1 : 32'd0);
            chk("fill_level", {27'd0, wlevel}, i + 1);
        end
        winc = 1'b0;
        chk("full_flag", {31'd0, wfull}, 32'd1);
        chk("full_gray", {27'd0, wptr_gray}, 32'b11000);
        chk("full_level", {27'd0, wlevel}, 32'd16);

        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = $urandom;
            #1;
            chk("ovf_wen_blocked", {31'd0, mem_wen}, 32'd0);
            step();
            chk("ovf_ptr_held", {27'd0, wptr_gray}, 32'b11000);
            chk("ovf_set", {31'd0, wovf}, 32'd1);
        end
        winc = 1'b0; wovf_clr = 1'b1;
        step();
        chk("ovf_cleared", {31'd0, wovf}, 32'd0);
        winc = 1'b1; wovf_clr = 1'b1;
        step();
        chk("ovf_set_wins", {31'd0, wovf}, 32'd1);
        winc = 1'b0;
        step();
        chk("ovf_cleared2", {31'd0, wovf}, 32'd0);
        wovf_clr = 1'b0;

        for (int k = 0; k < 4; k++) begin
            chk("rd_order", tbmem[k], sb.pop_front());
        end
        r_bin     = 5'd4;
        rptr_gray = 5'b00110;
        step();
        chk("full_hold_1", {31'd0, wfull}, 32'd1);
        step();
        chk("full_hold_2", {31'd0, wfull}, 32'd1);
        step();
        chk("full_drop_3", {31'd0, wfull}, 32'd0);
        chk("drop_level", {27'd0, wlevel}, 32'd12);
        chk("drop_afull", {31'd0, walmost_full}, 32'd1);

        do_reset();
        n_acc = 0;
        for (int cyc = 0; cyc < 400 && (n_acc < 40 || sb.size() > 0); cyc++) begin
            winc  = (n_acc < 40) && ($urandom_range(0, 3) != 0);
            wdata = $urandom;
            step();
            if (sb.size() > 0 && $urandom_range(0, 1) == 1) read_one();
        end
        winc = 1'b0;
        chk("mix_accepted", n_acc, 32'd40);
        chk("mix_drained", sb.size(), 32'd0);
        repeat (3) step();
        chk("mix_level_empty", {27'd0, wlevel}, 32'd0);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            winc  = 1'b1;
            wdata = $urandom;
            step();
        end
        chk("burst_level", {27'd0, wlevel}, 32'd9);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
